// File: rtl/dt_pack.sv
// Distance-map to packed bitmap converter: streams 128x128 8-bit pixels, thresholds each one,
// packs 16 bits per word MSB-first, and reports the foreground count and peak distance.
module dt_pack #(
  parameter bit SKIP_BORDER = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  thr,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        sti_wr,
  output logic [9:0]  sti_addr,
  output logic [15:0] sti_do,
  output logic [14:0] fg_count,
  output logic [7:0]  max_dist
);

  localparam logic [13:0] LAST_ADDR = 14'h3FFF;
  localparam logic [9:0]  LAST_WORD = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q;
  logic [7:0]  thr_q;
  logic        busy_q;
  logic        done_q;
  logic        rd_q;
  logic [13:0] addr_q;

  // Read-side tag delayed one cycle so it lines up with res_di.
  logic        pix_vld_q;
  logic [13:0] pix_addr_q;

  logic [15:0] word_q;
  logic [15:0] word_d;
  logic        wr_q;
  logic [9:0]  waddr_q;
  logic [15:0] wdata_q;
  logic [14:0] fg_q;
  logic [14:0] fg_d;
  logic [7:0]  max_q;
  logic [7:0]  max_d;

  logic        start_acc;
  logic        pix_border;
  logic        pix_counted;
  logic        pix_bit;

  assign start_acc = (state_q == IDLE) && start;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    pix_border  = (pix_addr_q[13:7] == 7'd0) || (&pix_addr_q[13:7]) ||
                  (pix_addr_q[6:0]  == 7'd0) || (&pix_addr_q[6:0]);
    pix_counted = pix_vld_q && !(SKIP_BORDER && pix_border);
    pix_bit     = pix_counted && (res_di > thr_q);
    word_d      = {word_q[14:0], pix_bit};
    fg_d        = fg_q + {14'd0, pix_bit};
    max_d       = (pix_counted && (res_di > max_q)) ? res_di : max_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      thr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            thr_q   <= thr;
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= '0;
          end
        end
        READ: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= DRAIN;
            rd_q    <= 1'b0;
          end else begin
            addr_q  <= addr_q + 14'd1;
          end
        end
        DRAIN: begin
          // Leave once the last word is on the bus, so busy covers that write.
          if (wr_q && (waddr_q == LAST_WORD)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_vld_q  <= 1'b0;
      pix_addr_q <= '0;
      word_q     <= '0;
      wr_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      fg_q       <= '0;
      max_q      <= '0;
    end else begin
      pix_vld_q  <= rd_q;
      pix_addr_q <= addr_q;
      wr_q       <= 1'b0;
      if (start_acc) begin
        word_q <= '0;
        fg_q   <= '0;
        max_q  <= '0;
      end else if (pix_vld_q) begin
        word_q <= word_d;
        fg_q   <= fg_d;
        max_q  <= max_d;
        if (&pix_addr_q[3:0]) begin
          wr_q    <= 1'b1;
          waddr_q <= pix_addr_q[13:4];
          wdata_q <= word_d;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = rd_q;
  assign res_addr = addr_q;
  assign sti_wr   = wr_q;
  assign sti_addr = waddr_q;
  assign sti_do   = wdata_q;
  assign fg_count = fg_q;
  assign max_dist = max_q;

endmodule

// File: tb/tb_dt_pack.sv
// Directed bench for dt_pack: two instances (border kept / border skipped) share one
// distance-map RAM model; a negedge monitor records read/write/done timing per pass.
module tb_dt_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        sel;
  int          cyc = 0;

  logic [7:0]  mem [16384];

  logic        a_busy, a_done, a_res_rd, a_sti_wr;
  logic [13:0] a_res_addr;
  logic [7:0]  a_res_di, a_max;
  logic [9:0]  a_sti_addr;
  logic [15:0] a_sti_do;
  logic [14:0] a_fg;

  logic        b_busy, b_done, b_res_rd, b_sti_wr;
  logic [13:0] b_res_addr;
  logic [7:0]  b_res_di, b_max;
  logic [9:0]  b_sti_addr;
  logic [15:0] b_sti_do;
  logic [14:0] b_fg;

  logic        start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  dt_pack #(.SKIP_BORDER(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start_a), .thr(thr),
    .busy(a_busy), .done(a_done), .res_rd(a_res_rd), .res_addr(a_res_addr), .res_di(a_res_di),
    .sti_wr(a_sti_wr), .sti_addr(a_sti_addr), .sti_do(a_sti_do),
    .fg_count(a_fg), .max_dist(a_max)
  );

  dt_pack #(.SKIP_BORDER(1'b1)) dut_sb (
    .clk(clk), .reset(reset), .start(start_b), .thr(thr),
    .busy(b_busy), .done(b_done), .res_rd(b_res_rd), .res_addr(b_res_addr), .res_di(b_res_di),
    .sti_wr(b_sti_wr), .sti_addr(b_sti_addr), .sti_do(b_sti_do),
    .fg_count(b_fg), .max_dist(b_max)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_res_rd) a_res_di <= mem[a_res_addr];
    if (b_res_rd) b_res_di <= mem[b_res_addr];
  end

  logic        m_busy, m_done, m_res_rd, m_sti_wr;
  logic [13:0] m_res_addr;
  logic [9:0]  m_sti_addr;
  logic [15:0] m_sti_do;
  logic [14:0] m_fg;
  logic [7:0]  m_max;

  always_comb begin
    m_busy     = sel ? b_busy     : a_busy;
    m_done     = sel ? b_done     : a_done;
    m_res_rd   = sel ? b_res_rd   : a_res_rd;
    m_res_addr = sel ? b_res_addr : a_res_addr;
    m_sti_wr   = sel ? b_sti_wr   : a_sti_wr;
    m_sti_addr = sel ? b_sti_addr : a_sti_addr;
    m_sti_do   = sel ? b_sti_do   : a_sti_do;
    m_fg       = sel ? b_fg       : a_fg;
    m_max      = sel ? b_max      : a_max;
  end

  // Monitor: counters restart whenever the stimulus opens a new pass (mon_epoch bump).
  int          mon_t = -100000;
  int          mon_epoch = 0;
  int          seen_epoch = 0;
  int          rd_cnt = 0, rd_bad = 0, wr_cnt = 0, wr_bad = 0;
  int          done_cnt = 0, done_bad = 0, busy_bad = 0;
  logic [15:0] wr_word [1024];

  always @(negedge clk) begin
    if (mon_epoch != seen_epoch) begin
      seen_epoch = mon_epoch;
      rd_cnt = 0; rd_bad = 0; wr_cnt = 0; wr_bad = 0;
      done_cnt = 0; done_bad = 0; busy_bad = 0;
    end
    if (m_res_rd) begin
      rd_cnt++;
      if (int'(m_res_addr) != cyc - mon_t - 1) rd_bad++;
    end
    if (m_sti_wr) begin
      if (cyc != mon_t + 18 + 16 * int'(m_sti_addr) || int'(m_sti_addr) != wr_cnt) wr_bad++;
      wr_word[m_sti_addr] = m_sti_do;
      wr_cnt++;
    end
    if (m_done) begin
      done_cnt++;
      if (cyc != mon_t + 16387) done_bad++;
    end
    if (m_busy != (cyc >= mon_t + 1 && cyc <= mon_t + 16386)) busy_bad++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon(input int t0);
    mon_t = t0;
    mon_epoch++;
  endtask

  task automatic do_start(input logic [7:0] t_acc, input logic [7:0] t_after, output int t0);
    start = 1'b1;
    thr   = t_acc;
    t0    = cyc;
    clear_mon(t0);
    step_to(t0 + 1);
    start = 1'b0;
    thr   = t_after;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     32'(m_busy),     32'd0);
    check({tag, "_done"},     32'(m_done),     32'd0);
    check({tag, "_res_rd"},   32'(m_res_rd),   32'd0);
    check({tag, "_res_addr"}, 32'(m_res_addr), 32'd0);
    check({tag, "_sti_wr"},   32'(m_sti_wr),   32'd0);
    check({tag, "_sti_addr"}, 32'(m_sti_addr), 32'd0);
    check({tag, "_sti_do"},   32'(m_sti_do),   32'd0);
    check({tag, "_fg"},       32'(m_fg),       32'd0);
    check({tag, "_max"},      32'(m_max),      32'd0);
  endtask

  function automatic bit is_border(input int a);
    return (a / 128 == 0) || (a / 128 == 127) || (a % 128 == 0) || (a % 128 == 127);
  endfunction

  // Expected packed words from the RAM contents: col c of a word sits at bit 15-(c%16).
  task automatic check_full(input string tag, input logic [7:0] t, input bit sb);
    int          bad;
    logic [15:0] e;
    bad = 0;
    for (int w = 0; w < 1024; w++) begin
      e = '0;
      for (int i = 0; i < 16; i++)
        if (mem[16 * w + i] > t && !(sb && is_border(16 * w + i))) e[15 - i] = 1'b1;
      if (wr_word[w] !== e) bad++;
    end
    check({tag, "_words_bad"}, 32'(bad),      32'd0);
    check({tag, "_wr_cnt"},    32'(wr_cnt),   32'd1024);
    check({tag, "_wr_timing"}, 32'(wr_bad),   32'd0);
    check({tag, "_rd_cnt"},    32'(rd_cnt),   32'd16384);
    check({tag, "_rd_seq"},    32'(rd_bad),   32'd0);
    check({tag, "_done_cnt"},  32'(done_cnt), 32'd1);
    check({tag, "_done_time"}, 32'(done_bad), 32'd0);
    check({tag, "_busy_win"},  32'(busy_bad), 32'd0);
  endtask

  initial begin
    int          t0;
    int          t2;
    int          bad;
    int          row;
    logic [15:0] e;

    reset = 1'b1;
    start = 1'b0;
    thr   = 8'd0;
    sel   = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    check_idle("rst");

    // Pass A: all-zero map, stray start pulses mid-pass and in DONE are ignored.
    do_start(8'd0, 8'd0, t0);
    step_to(t0 + 100);
    start = 1'b1;
    step_to(t0 + 101);
    start = 1'b0;
    step_to(t0 + 16387);
    check("a_done_pulse", 32'(m_done), 32'd1);
    check("a_fg", 32'(m_fg), 32'd0);
    check("a_max", 32'(m_max), 32'd0);
    start = 1'b1;
    step_to(t0 + 16388);
    start = 1'b0;
    step_to(t0 + 16389);
    check("a_no_restart_busy", 32'(m_busy), 32'd0);
    check("a_no_restart_rd", 32'(m_res_rd), 32'd0);
    check_full("a", 8'd0, 1'b0);

    // Pass B: single pixel at row 5 col 17; start held through DRAIN/DONE restarts.
    mem[657] = 8'd3;
    do_start(8'd0, 8'd0, t0);
    step_to(t0 + 16386);
    start = 1'b1;
    step_to(t0 + 16387);
    check("b_fg", 32'(m_fg), 32'd1);
    check("b_max", 32'(m_max), 32'd3);
    step_to(t0 + 16388);
    check("b_fg_stable", 32'(m_fg), 32'd1);
    check("b_word41", 32'(wr_word[41]), 32'h4000);
    check_full("b", 8'd0, 1'b0);
    t2 = t0 + 16388;
    clear_mon(t2);
    step_to(t2 + 1);
    start = 1'b0;
    check("restart_rd", 32'(m_res_rd), 32'd1);
    check("restart_addr", 32'(m_res_addr), 32'd0);
    check("restart_busy", 32'(m_busy), 32'd1);
    check("restart_fg_clr", 32'(m_fg), 32'd0);
    check("restart_max_clr", 32'(m_max), 32'd0);

    // Mid-pass reset: words 0..311 are already out, nothing after.
    step_to(t2 + 5000);
    reset = 1'b1;
    step_to(t2 + 5001);
    reset = 1'b0;
    check_idle("midrst");
    step_to(t2 + 5300);
    check("midrst_wr_cnt", 32'(wr_cnt), 32'd312);
    check("midrst_wr_timing", 32'(wr_bad), 32'd0);
    check("midrst_rd_cnt", 32'(rd_cnt), 32'd5000);

    // Pass C: threshold is strict and latched; thr dropped to 0 after acceptance.
    mem[657] = 8'd0;
    mem[0] = 8'd1;
    mem[1] = 8'd2;
    mem[2] = 8'd3;
    do_start(8'd2, 8'd0, t0);
    step_to(t0 + 16388);
    check("c_word0", 32'(wr_word[0]), 32'h2000);
    check("c_fg", 32'(m_fg), 32'd1);
    check("c_max", 32'(m_max), 32'd3);
    check_full("c", 8'd2, 1'b0);

    // Pass D: border-skipping instance on a saturated map.
    for (int i = 0; i < 16384; i++) mem[i] = 8'd255;
    sel = 1'b1;
    step_to(cyc + 2);
    do_start(8'd0, 8'd0, t0);
    step_to(t0 + 16388);
    check("d_fg", 32'(m_fg), 32'd15876);
    check("d_max", 32'(m_max), 32'd255);
    check("d_word0", 32'(wr_word[0]), 32'h0000);
    check("d_word8", 32'(wr_word[8]), 32'h7FFF);
    check("d_word9", 32'(wr_word[9]), 32'hFFFF);
    check("d_word15", 32'(wr_word[15]), 32'hFFFE);
    check("d_word1023", 32'(wr_word[1023]), 32'h0000);
    bad = 0;
    for (int w = 0; w < 1024; w++) begin
      row = w / 8;
      if (row == 0 || row == 127) e = 16'h0000;
      else if (w % 8 == 0)        e = 16'h7FFF;
      else if (w % 8 == 7)        e = 16'hFFFE;
      else                        e = 16'hFFFF;
      if (wr_word[w] !== e) bad++;
    end
    check("d_words_rule", 32'(bad), 32'd0);
    check_full("d", 8'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dt_pack.md
DT_PACK -- requirements
Module: dt_pack

Interface
REQ-001 Parameter SKIP_BORDER, default 0. When 1, border pixels (row 0/127, col 0/127) are forced to bit 0 and excluded from the statistics.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 start  input  1  starts one pack pass; sampled only in IDLE.
REQ-005 thr  input  8  threshold, latched on the cycle start is accepted.
REQ-006 busy  output  1  high while a pass is in progress.
REQ-007 done  output  1  one-cycle pulse at the end of a pass.
REQ-008 res_rd  output  1  distance-map RAM read strobe.
REQ-009 res_addr  output  14  pixel address = 128*row + col.
REQ-010 res_di  input  8  read data, valid the cycle after res_rd.
REQ-011 sti_wr  output  1  packed-bitmap write strobe, one cycle per word.
REQ-012 sti_addr  output  10  word address = pixel_addr >> 4.
REQ-013 sti_do  output  16  packed word; pixel col c maps to bit 15-(c%16), so the MSB is the leftmost pixel.
REQ-014 fg_count  output  15  number of 1-bits written in the last pass.
REQ-015 max_dist  output  8  maximum res_di over counted pixels in the last pass.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, DRAIN and DONE, with these transitions:
- IDLE -> READ on start.
- READ -> DRAIN after address 16383 is issued.
- DRAIN -> DONE once the final word is written.
- DONE -> IDLE unconditionally.
REQ-017 On accepting start at cycle T, the block SHALL clear fg_count and max_dist and latch thr.
REQ-018 In READ the block SHALL assert res_rd with res_addr=k at cycle T+1+k, for k = 0..16383, one address per cycle with no gaps.
REQ-019 The pixel bit SHALL be 1 iff res_di > latched thr (unsigned); thr=0 therefore reproduces the binary source image.
REQ-020 Bits SHALL be shifted into the word in ascending column order; after 16 pixels the word is complete.
REQ-021 Word w SHALL be written with sti_wr=1, sti_addr=w and sti_do=word at cycle T+18+16w; sti_wr is 0 in every other cycle.
REQ-022 Exactly 1024 writes SHALL occur per pass; the last write is at T+16386.
REQ-023 done SHALL pulse at T+16387; busy is high from T+1 through T+16386 inclusive.
REQ-024 fg_count SHALL increment by 1 per 1-bit (maximum 16384 needs 15 bits, so no overflow); max_dist SHALL update with res_di when res_di > max_dist.
REQ-025 fg_count and max_dist SHALL be stable from done until the next accepted start.
REQ-026 start while busy or in DONE SHALL be ignored; if start is held high through DONE, a new pass is accepted in the following IDLE cycle.
REQ-027 thr changes after acceptance SHALL have no effect on the current pass.
REQ-028 With SKIP_BORDER=1, border pixels SHALL still be read, but they contribute 0 bits and do not update fg_count or max_dist.

Reset
REQ-029 On reset the block SHALL enter IDLE with all outputs at 0: busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do, fg_count, max_dist.
REQ-030 Reset mid-pass SHALL abort at the next edge, with no further sti_wr; words already written are left untouched and the partial word is discarded.
REQ-031 Reset SHALL take priority over start in the same cycle.

Verification
REQ-032 All-zero res RAM, thr=0, start at T -> 1024 writes of 0x0000 at T+18+16w, done at T+16387, fg_count=0, max_dist=0.
REQ-033 res[657]=3 (row 5, col 17), others 0, thr=0 -> word 41 = 0x4000, all other words 0, fg_count=1, max_dist=3.
REQ-034 Pixels 0,1,2 hold 1,2,3 and thr=2 -> word 0 = 0x2000, fg_count=1, max_dist=3.
REQ-035 Start pulsed again at T+100 and T+16387 -> both ignored; a single done pulse; start held through DONE -> restart at T+16388 with res_addr=0 at T+16389.
REQ-036 reset at T+5000 -> at the next edge all outputs are 0 and the FSM is in IDLE; no sti_wr after T+5000; a fresh start gives a full correct pass.
REQ-037 SKIP_BORDER=1, all res=255, thr=0:
- Row 0 and row 127 words = 0x0000.
- Interior rows: column-0 word = 0x7FFF, column-112 word = 0xFFFE, all others 0xFFFF.
- fg_count=15876, max_dist=255.
